// File: rtl/uart_packetizer.sv
// uart_packetizer
//   Buffers payload bytes in a small FIFO and, on request, frames the buffered
//   bytes as a packet (SOF, LEN, payload..., CHECKSUM) handed one 10-bit UART
//   frame at a time to a downstream transmitter.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_data    payload byte to buffer
//   in_valid   in_data valid
//   in_ready   FIFO not full (combinational)
//   pkt_send   one-cycle request to send the current FIFO contents
//   tx_ready   transmitter idle and able to accept start_tx
//   tx_busy    transmitter shifting a frame
//   start_tx   one-cycle launch pulse to the transmitter
//   tx_data    frame {stop=1, byte, start=0}; 10'h3FF when idle
//   pkt_busy   packet in progress
//   fifo_count FIFO occupancy, 0..FIFO_DEPTH
//   overflow   pulses for the cycle in which an incoming byte is dropped
module uart_packetizer #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned ADDR_W     = 4,
   parameter logic [7:0]  SOF_BYTE   = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              pkt_send,
   input  logic              tx_ready,
   input  logic              tx_busy,
   output logic              start_tx,
   output logic [9:0]        tx_data,
   output logic              pkt_busy,
   output logic [ADDR_W:0]   fifo_count,
   output logic              overflow
);

   localparam logic [ADDR_W:0] DepthCnt = (ADDR_W+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWaitBusy, StWaitDone} state_t;
   typedef enum logic [1:0] {SelSof, SelLen, SelPay, SelCsum} sel_t;

   // FIFO
   logic [7:0]        mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              wr_en;
   logic              pop;
   logic [7:0]        head;

   // Packet sequencing
   state_t            state;
   sel_t              sel;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   remaining;
   logic [7:0]        checksum;
   logic [7:0]        cur_byte;

   assign full       = (count == DepthCnt);
   assign in_ready   = !full;
   assign wr_en      = in_valid && !full;
   assign overflow   = in_valid && full;
   assign fifo_count = count;
   assign head       = mem[rd_ptr];
   assign pkt_busy   = (state != StIdle);

   // Launch only from ISSUE with an idle transmitter; the launch cycle of a
   // payload byte is also its pop cycle, so backpressure never pops twice.
   assign start_tx = (state == StIssue) && tx_ready && !tx_busy;
   assign pop      = start_tx && (sel == SelPay);

   always_comb begin
      cur_byte = SOF_BYTE;
      unique case (sel)
         SelSof:  cur_byte = SOF_BYTE;
         SelLen:  cur_byte = 8'(len);
         SelPay:  cur_byte = head;
         SelCsum: cur_byte = checksum;
         default: cur_byte = SOF_BYTE;
      endcase
   end

   // Storage has no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + (ADDR_W+1)'(1);
            2'b01:   count <= count - (ADDR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         sel       <= SelSof;
         len       <= '0;
         remaining <= '0;
         checksum  <= '0;
         tx_data   <= 10'h3FF;
      end else begin
         case (state)
            StIdle: begin
               tx_data <= 10'h3FF;
               if (pkt_send && (count != '0)) begin
                  // LEN is the occupancy at acceptance; later writes wait for
                  // the next packet.
                  len       <= count;
                  remaining <= count;
                  checksum  <= 8'(count);
                  sel       <= SelSof;
                  state     <= StLoad;
               end
            end
            StLoad: begin
               tx_data <= {1'b1, cur_byte, 1'b0};
               state   <= StIssue;
            end
            StIssue: begin
               if (start_tx) begin
                  state <= StWaitBusy;
                  if (pop) begin
                     checksum  <= checksum + head;
                     remaining <= remaining - (ADDR_W+1)'(1);
                  end
               end
            end
            StWaitBusy: begin
               if (tx_busy) state <= StWaitDone;
            end
            StWaitDone: begin
               if (!tx_busy && tx_ready) begin
                  state <= StLoad;
                  unique case (sel)
                     SelSof: sel <= SelLen;
                     SelLen: sel <= SelPay;
                     SelPay: begin
                        if (remaining == '0) sel <= SelCsum;
                     end
                     SelCsum: begin
                        sel     <= SelSof;
                        state   <= StIdle;
                        tx_data <= 10'h3FF;
                     end
                     default: sel <= SelSof;
                  endcase
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_packetizer.sv
// Self-checking bench for uart_packetizer with a simple transmitter model and
// a frame scoreboard.
module tb_uart_packetizer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       pkt_send;
   logic       tx_ready;
   logic       tx_busy;
   logic       start_tx;
   logic [9:0] tx_data;
   logic       pkt_busy;
   logic [4:0] fifo_count;
   logic       overflow;

   uart_packetizer #(
      .FIFO_DEPTH (16),
      .ADDR_W     (4),
      .SOF_BYTE   (8'hA5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .pkt_send   (pkt_send),
      .tx_ready   (tx_ready),
      .tx_busy    (tx_busy),
      .start_tx   (start_tx),
      .tx_data    (tx_data),
      .pkt_busy   (pkt_busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int n_starts = 0;

   logic [9:0] exp_q[$];
   logic [7:0] model_q[$];

   // Transmitter model: busy for 4 cycles after each launch.
   logic       tx_en;
   logic [2:0] busy_cnt;
   assign tx_busy  = (busy_cnt != 3'd0);
   assign tx_ready = (busy_cnt == 3'd0) && tx_en;

   always @(posedge clk) begin
      if (rst)                    busy_cnt <= 3'd0;
      else if (start_tx)          busy_cnt <= 3'd4;
      else if (busy_cnt != 3'd0)  busy_cnt <= busy_cnt - 3'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [9:0] frm(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

   // Scoreboard monitor: every launch must match the next expected frame and
   // launches must never be back to back.
   logic prev_start = 1'b0;
   always @(negedge clk) begin
      if (!rst && start_tx) begin
         n_starts++;
         if (exp_q.size() == 0) check("unexpected_start", 32'(tx_data), 32'h3FF);
         else                   check("frame", 32'(tx_data), 32'(exp_q.pop_front()));
         if (prev_start) check("start_consecutive", 32'(start_tx), 32'd0);
      end
      prev_start = start_tx;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; pkt_send = 1'b0; in_data = 8'h00; tx_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      model_q.delete();
      @(negedge clk);
      check("rst_start_tx", 32'(start_tx), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'h3FF);
      check("rst_pkt_busy", 32'(pkt_busy), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      cyc();
   endtask

   task automatic write_byte(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      if (model_q.size() == 16) begin
         check("overflow_pulse", 32'(overflow), 32'd1);
      end else begin
         check("no_overflow", 32'(overflow), 32'd0);
         model_q.push_back(b);
      end
      cyc();
      in_valid = 1'b0;
   endtask

   // accept: whether the bench expects this request to start a packet.
   task automatic pulse_send(input bit accept);
      logic [7:0] sum;
      logic [7:0] b;
      int         len;
      pkt_send = 1'b1;
      @(negedge clk);
      if (accept) begin
         len = model_q.size();
         sum = 8'(len);
         exp_q.push_back(frm(8'hA5));
         exp_q.push_back(frm(8'(len)));
         for (int i = 0; i < len; i++) begin
            b = model_q.pop_front();
            sum = sum + b;
            exp_q.push_back(frm(b));
         end
         exp_q.push_back(frm(sum));
      end
      cyc();
      pkt_send = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 3000 && (exp_q.size() != 0 || pkt_busy); i++) @(negedge clk);
      check("idle_timeout", 32'(i < 3000), 32'd1);
      cyc();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int target;
      int k;
      rst = 1'b1;
      do_reset();

      // Basic packet with launch-latency check.
      write_byte(8'h11);
      write_byte(8'h22);
      write_byte(8'h33);
      check("basic_count", 32'(fifo_count), 32'd3);
      pulse_send(1'b1);
      @(negedge clk);
      check("lat_load_busy", 32'(pkt_busy), 32'd1);
      check("lat_load_nostart", 32'(start_tx), 32'd0);
      cyc();
      @(negedge clk);
      check("lat_issue_start", 32'(start_tx), 32'd1);
      cyc();
      wait_idle();
      check("basic_count_end", 32'(fifo_count), 32'd0);
      check("basic_idle_line", 32'(tx_data), 32'h3FF);

      // Checksum wrap.
      write_byte(8'hFF);
      write_byte(8'hFF);
      pulse_send(1'b1);
      wait_idle();

      // Full FIFO and overflow.
      for (int i = 0; i < 16; i++) write_byte(8'(8'h40 + i));
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_count", 32'(fifo_count), 32'd16);
      cyc();
      write_byte(8'hEE);
      @(negedge clk);
      check("overflow_single", 32'(overflow), 32'd0);
      check("overflow_count", 32'(fifo_count), 32'd16);
      cyc();
      pulse_send(1'b1);
      wait_idle();
      check("full_count_end", 32'(fifo_count), 32'd0);

      // Backpressure in ISSUE.
      write_byte(8'h01);
      tx_en = 1'b0;
      pulse_send(1'b1);
      cyc();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_no_start", 32'(start_tx), 32'd0);
         check("bp_tx_data", 32'(tx_data), 32'h34A);
         cyc();
      end
      tx_en = 1'b1;
      @(negedge clk);
      check("bp_release", 32'(start_tx), 32'd1);
      cyc();
      wait_idle();

      // Concurrent write and ignored request.
      write_byte(8'h10);
      write_byte(8'h20);
      pulse_send(1'b1);
      repeat (3) cyc();
      write_byte(8'h55);
      pulse_send(1'b0);
      @(negedge clk);
      check("concur_busy", 32'(pkt_busy), 32'd1);
      cyc();
      wait_idle();
      check("concur_count", 32'(fifo_count), 32'd1);
      pulse_send(1'b1);
      wait_idle();
      check("concur_count_end", 32'(fifo_count), 32'd0);

      // Reset during WAIT_DONE of the payload byte.
      write_byte(8'h77);
      target = n_starts + 3;
      pulse_send(1'b1);
      for (k = 0; k < 200 && n_starts < target; k++) @(negedge clk);
      check("mid_wait_timeout", 32'(k < 200), 32'd1);
      cyc();
      cyc();
      check("mid_busy_before", 32'(pkt_busy), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      exp_q.delete();
      model_q.delete();
      @(negedge clk);
      check("mid_pkt_busy", 32'(pkt_busy), 32'd0);
      check("mid_count", 32'(fifo_count), 32'd0);
      check("mid_tx_data", 32'(tx_data), 32'h3FF);
      target = n_starts;
      repeat (30) cyc();
      check("mid_no_start", 32'(n_starts), 32'(target));

      // Request with an empty FIFO is ignored.
      pulse_send(1'b0);
      repeat (10) cyc();
      @(negedge clk);
      check("empty_pkt_busy", 32'(pkt_busy), 32'd0);
      check("empty_no_start", 32'(n_starts), 32'(target));
      check("empty_tx_data", 32'(tx_data), 32'h3FF);
      check("final_queue", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_packetizer.md
Name: uart_packetizer

Overview:
- Upstream stage of UART_Transmitter. Buffers payload bytes in an internal FIFO.
- On command, frames them as a packet: SOF, LEN, payload, CHECKSUM.
- Hands each byte to the transmitter as a 10-bit UART frame via the start_tx / tx_busy / tx_ready handshake.

Parameters:
- FIFO_DEPTH, 16, payload FIFO entries (power of two).
- ADDR_W, 4, log2(FIFO_DEPTH).
- SOF_BYTE, 8'hA5, start-of-packet marker byte.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  8  payload byte
- in_valid  input  1  in_data valid
- in_ready  output  1  FIFO can accept; equals !full (combinational)
- pkt_send  input  1  single-cycle request to packetize current FIFO contents
- tx_ready  input  1  transmitter idle and able to accept start_tx
- tx_busy  input  1  transmitter shifting a frame
- start_tx  output  1  one-cycle launch pulse to transmitter
- tx_data  output  10  frame: [0]=start bit 0, [8:1]=byte (LSB at [1]), [9]=stop bit 1
- pkt_busy  output  1  packet in progress (state != IDLE)
- fifo_count  output  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH
- overflow  output  1  one-cycle pulse when a byte is dropped

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - start_tx=0, tx_data=10'h3FF (idle line), pkt_busy=0, overflow=0.
  - FIFO empty, fifo_count=0, state=IDLE, checksum=0.
  - in_ready is 1 on the first cycle after rst deasserts.
- Reset mid-packet: FIFO contents are discarded and the FSM aborts to IDLE. No further start_tx is issued.
- FIFO behaviour:
  - Write when in_valid && in_ready.
  - in_valid while full: byte dropped, overflow=1 for that cycle, fifo_count unchanged.
  - Simultaneous write and pop: both occur, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Head byte is read combinationally; pop occurs in the ISSUE cycle of a payload byte.
- Packet start:
  - pkt_send in IDLE with fifo_count>0: latch LEN=fifo_count, seed checksum=LEN[7:0], go to LOAD with sel=SOF.
  - pkt_send in IDLE with fifo_count=0: ignored.
  - pkt_send while pkt_busy: ignored, not queued.
- Bytes written during a packet are retained for the next packet. Exactly LEN payload bytes are popped.
- Byte sequence: SOF_BYTE, LEN, payload[0..LEN-1], CHECKSUM.
- Checksum: 8-bit sum mod 256 of LEN and all payload bytes. Each payload byte is added at its pop. SOF is excluded.
- FSM states:
  - IDLE: waits for a valid pkt_send.
  - LOAD: tx_data <= {1'b1, byte, 1'b0}; go to ISSUE next cycle.
  - ISSUE: if tx_ready=1 and tx_busy=0, start_tx=1 for exactly this cycle and go to WAIT_BUSY; otherwise hold with start_tx=0.
  - WAIT_BUSY: stay until tx_busy=1.
  - WAIT_DONE: stay until tx_busy=0 and tx_ready=1. Then advance sel and go to LOAD, or to IDLE after CHECKSUM.
- tx_data is held stable from LOAD through WAIT_DONE exit. It returns to 10'h3FF in IDLE.
- Latency: pkt_send accepted at cycle N gives LOAD at N+1 and the earliest start_tx at N+2.
- start_tx is never asserted outside ISSUE and never on two consecutive cycles.

Test Plan:
- Basic packet: after reset, write 0x11, 0x22, 0x33, then pulse pkt_send.
  - Expect 6 start_tx pulses.
  - tx_data sequence: 0x34A (A5), 0x206 (03), 0x222, 0x244, 0x266, 0x2D2 (CSUM 0x69).
  - fifo_count ends at 0.
- Checksum wrap: payload 0xFF, 0xFF -> LEN=0x02, CSUM=0x00, last frame tx_data=0x200.
- Full FIFO: 16 writes -> in_ready=0, fifo_count=16. A 17th in_valid gives overflow=1 for one cycle and the byte is absent from the sent packet (LEN=0x10).
- Backpressure: hold tx_ready=0 for 20 cycles in ISSUE -> start_tx stays 0 and tx_data stays stable; the pulse follows the first cycle tx_ready=1.
- Concurrent writes and ignored requests: during packet of 2 bytes, write 0x55 and pulse pkt_send.
  - Current packet LEN=2; the second pkt_send is ignored.
  - fifo_count=1 afterwards; a later pkt_send sends LEN=1, payload 0x55, CSUM 0x56.
- Reset mid-packet: assert rst during WAIT_DONE of the payload byte -> next cycle pkt_busy=0, fifo_count=0, tx_data=0x3FF, no further start_tx. pkt_send with an empty FIFO -> no activity.
